mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single-ported, byte-addressed instruction/data memory between the instruction-fetch port and the load/store data port of the RISC-V core. It arbitrates between the two requesters round-robin and issues word reads in one memory cycle. Because the memory writes one byte per cycle, it splits byte, half and word stores into sequential byte writes. It sits between the fetch/LSU stages and the memory, and is the only driver of the memory's `address`, `i_val` and `op_type` inputs.

## Interface
Parameters:
- `ADDR_W`, default 32: address width on all ports.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_valid`  out  1  one-cycle pulse: `if_rdata` valid.
- `if_rdata`  out  32  fetched word.
- `d_req`  in  1  data request; payload held stable until `d_gnt`.
- `d_we`  in  1  0 = load, 1 = store.
- `d_size`  in  2  store size: 00 byte, 01 half, 10 word, 11 treated as word.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  32  store data, little-endian.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_valid`  out  1  one-cycle pulse: load data valid, or store complete.
- `d_rdata`  out  32  loaded word; 0 on store completion.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  32  write byte in [7:0]; [31:8] always 0.
- `mem_op`  out  1  0 read, 1 write.
- `mem_rdata`  in  32  memory read word; combinational from `mem_addr`.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- States: IDLE, READ, WRITE.
- **IDLE:**
  - Grant is combinational: `if_gnt`/`d_gnt` are high in the same cycle as the winning request.
  - At the end of that cycle the payload is latched and the state changes.
  - Only one transaction is outstanding at a time; no grant is given outside IDLE.
- **Arbitration:**
  - With a single requester, that requester wins.
  - With both requesting, the port not granted last wins.
  - The `last` pointer resets to fetch, so data wins the first tie after reset.
- **IDLE transitions:**
  - Fetch, or data with `d_we=0`: go to READ.
  - Data with `d_we=1`: go to WRITE with byte counter k=0 and N = 1, 2 or 4 from `d_size`.
- **READ (1 cycle):**
  - `mem_addr` = latched address, `mem_op`=0.
  - `mem_rdata` is registered into the owner's rdata register.
  - Next state is IDLE; the owner's valid output pulses in the following cycle.
- **WRITE (N cycles):**
  - `mem_addr` = addr+k, `mem_op`=1, `mem_wdata` = {24'b0, wdata[8k+7:8k]}.
  - k increments each cycle.
  - After byte N-1 the state returns to IDLE and `d_valid` pulses the next cycle with `d_rdata`=0.
- **Address and width rules:**
  - Address arithmetic is ADDR_W wide and wraps modulo 2^ADDR_W.
  - No alignment check is done; the memory applies its own base offset.
  - Loads always return the full word; sign/zero extension is done in the LSU.
- **Outside READ/WRITE:** `mem_addr`=0, `mem_op`=0, `mem_wdata`=0.
- **Valid overlapping a grant:** a valid pulse may coincide with a new grant in IDLE. Both are honoured independently.

## Timing
- Reset values: all outputs 0, state IDLE, k=0, `last`=fetch.
- **Reset mid-transaction:**
  - The transaction is aborted and remaining bytes are not written.
  - No valid pulse is produced.
  - All outputs are 0 in the cycle after the reset edge.
- **Read:** gnt in cycle 0, memory access in cycle 1, valid in cycle 2. The next grant is possible in cycle 2.
- **Store:** gnt in cycle 0, bytes in cycles 1..N, `d_valid` in cycle N+1. Word store takes 5 cycles to valid.
- **Held request:** a request that is held while the arbiter is busy is granted in the first IDLE cycle, subject to round-robin.
- **Request dropped before grant:** nothing happens.
- **Throughput:** one read per 2 cycles; one store per N+1 cycles.

## Structure
- Add to `constants.vh`:
  - size encodings `_MEM_SZ_BYTE`, `_MEM_SZ_HALF`, `_MEM_SZ_WORD`;
  - state encodings `_ARB_IDLE`, `_ARB_READ`, `_ARB_WRITE`;
  - owner encodings `_ARB_OWN_IF`, `_ARB_OWN_D`.
- Sub-module `rr_pick2`: combinational 2-way round-robin picker. Inputs are the two requests and `last`; outputs are one-hot grants. The `last` register stays in `mem_port_arbiter`.

## Test plan
1. After reset: `if_req` with `if_addr`=0x100, memory returns 0xDEADBEEF → `if_gnt` in cycle 0; cycle 1 `mem_addr`=0x100, `mem_op`=0; cycle 2 `if_valid`=1 with `if_rdata`=0xDEADBEEF.
2. `if_req` and `d_req` (load 0x200) both held from reset → `d_gnt` in cycle 0, `if_gnt` in cycle 2; fetch wins the next tie.
3. Word store to 0x200 with data 0x11223344 → cycles 1–4 write 0x44@0x200, 0x33@0x201, 0x22@0x202, 0x11@0x203; `d_valid` in cycle 5 with `d_rdata`=0.
4. Half store to 0x300 with data 0xAABBCCDD → 0xDD@0x300, 0xCC@0x301, `d_valid` in cycle 3. Byte store → 0xDD@0x300 only, `d_valid` in cycle 2.
5. `rst` asserted during cycle 2 of a word store → only bytes 0 and 1 written; no `d_valid`; all outputs 0 next cycle; next tie goes to data.
6. `if_req` asserted during a word store → `if_gnt` held low until IDLE in cycle 5, then fetch granted; `busy` high in cycles 1–4.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: size, state and owner
// encodings plus the store-length decode.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_SZ_BYTE = 2'b00,
    MEM_SZ_HALF = 2'b01,
    MEM_SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_READ  = 2'b01,
    ARB_WRITE = 2'b10
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_IF = 1'b0,
    ARB_OWN_D  = 1'b1
  } arb_owner_t;

  // Index of the final byte of a store; size 2'b11 behaves as a word.
  function automatic logic [1:0] store_last_byte(input logic [1:0] size);
    case (size)
      MEM_SZ_BYTE: store_last_byte = 2'd0;
      MEM_SZ_HALF: store_last_byte = 2'd1;
      default:     store_last_byte = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that was not granted last. Purely combinational; one-hot outputs.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  arb_owner_t last,
  output logic       if_pick,
  output logic       d_pick
);

  always_comb begin
    if_pick = if_req & (~d_req | (last == ARB_OWN_D));
    d_pick  = d_req  & (~if_req | (last == ARB_OWN_IF));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported byte-write memory between instruction fetch and
// the load/store port; reads take one cycle, stores are split into byte writes.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_op,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  arb_state_t        state, state_next;
  arb_owner_t        last, owner;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        k, k_last;
  logic              if_pick, d_pick;
  logic              grant_ok;

  rr_pick2 u_pick (
    .if_req  (if_req),
    .d_req   (d_req),
    .last    (last),
    .if_pick (if_pick),
    .d_pick  (d_pick)
  );

  // Grants are suppressed while rst is high so every output reads 0 in reset.
  assign grant_ok = (state == ARB_IDLE) & ~rst;
  assign if_gnt   = grant_ok & if_pick;
  assign d_gnt    = grant_ok & d_pick;

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (d_gnt)       state_next = d_we ? ARB_WRITE : ARB_READ;
        else if (if_gnt) state_next = ARB_READ;
      end
      ARB_READ:  state_next = ARB_IDLE;
      ARB_WRITE: if (k == k_last) state_next = ARB_IDLE;
      default:   state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_op    = 1'b0;
    mem_wdata = '0;
    busy      = (state != ARB_IDLE);
    case (state)
      ARB_READ: mem_addr = addr_q;
      ARB_WRITE: begin
        mem_addr  = addr_q + ADDR_W'(k);
        mem_op    = 1'b1;
        mem_wdata = {24'b0, wdata_q[{k, 3'b000} +: 8]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= ARB_OWN_IF;
      owner    <= ARB_OWN_IF;
      addr_q   <= '0;
      wdata_q  <= '0;
      k        <= '0;
      k_last   <= '0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (d_gnt) begin
            owner   <= ARB_OWN_D;
            last    <= ARB_OWN_D;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            k       <= '0;
            k_last  <= store_last_byte(d_size);
          end else if (if_gnt) begin
            owner  <= ARB_OWN_IF;
            last   <= ARB_OWN_IF;
            addr_q <= if_addr;
            k      <= '0;
          end
        end
        ARB_READ: begin
          if (owner == ARB_OWN_IF) begin
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
          end else begin
            d_rdata <= mem_rdata;
            d_valid <= 1'b1;
          end
        end
        ARB_WRITE: begin
          k <= k + 2'd1;
          if (k == k_last) begin
            k       <= '0;
            d_rdata <= '0;
            d_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
